ec_point_unit: RTL and testbench

Unified affine elliptic-curve point add/double engine over GF(p), for curves y² = x³ + ax + b. It is the next-generation replacement for the single-mode doubling block. Mode is selected per operation, and point-at-infinity inputs and outputs are handled explicitly. Control is a start/busy/done handshake, and latency is deterministic. It sits below the scalar-multiplication sequencer, which issues one add or double per step.

---
 rtl/ec_pkg.sv | 35 +++
 rtl/mod_mul_serial.sv | 51 +++++
 rtl/ec_point_unit.sv | 204 ++++++++++++++++++++
 tb/tb_ec_point_unit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ec_pkg.sv
// rtl/ec_pkg.sv - shared state encoding, mode constants and modular add/sub helpers
package ec_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_SPECIAL, S_SQR, S_NUMDEN, S_INV,
        S_LAM, S_LAM2, S_X3, S_Y3, S_FIN, S_DONE
    } ec_state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_DBL = 1'b1;

    // Widest supported field; callers extend operands in and truncate the result back.
    localparam int EC_W_MAX = 256;

    function automatic logic [EC_W_MAX-1:0] mod_add(input logic [EC_W_MAX-1:0] x,
                                                    input logic [EC_W_MAX-1:0] y,
                                                    input logic [EC_W_MAX-1:0] m);
        logic [EC_W_MAX:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m})
            s = s - {1'b0, m};
        return s[EC_W_MAX-1:0];
    endfunction

    function automatic logic [EC_W_MAX-1:0] mod_sub(input logic [EC_W_MAX-1:0] x,
                                                    input logic [EC_W_MAX-1:0] y,
                                                    input logic [EC_W_MAX-1:0] m);
        logic [EC_W_MAX:0] s;
        s = {1'b0, x} - {1'b0, y};
        if (x < y)
            s = s + {1'b0, m};
        return s[EC_W_MAX-1:0];
    endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// rtl/mod_mul_serial.sv - interleaved MSB-first modular multiplier, one multiplier bit per cycle
// o_done strobes during the last iteration; o_p carries the finished product in that cycle.
module mod_mul_serial
    import ec_pkg::*;
#(
    parameter int N = 231
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_p,
    output logic         o_done,
    output logic [N-1:0] o_p
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  w_dbl;
    logic [N-1:0]  w_addend;
    logic [N-1:0]  w_step;

    assign w_dbl    = N'(mod_add(EC_W_MAX'(r_acc), EC_W_MAX'(r_acc), EC_W_MAX'(i_p)));
    assign w_addend = r_b[N-1] ? r_a : '0;
    assign w_step   = N'(mod_add(EC_W_MAX'(w_dbl), EC_W_MAX'(w_addend), EC_W_MAX'(i_p)));
    assign o_done   = (r_cnt == CW'(1));
    assign o_p      = w_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_acc <= '0;
            r_a   <= i_a;
            r_b   <= i_b;
            r_cnt <= CW'(N);
        end else if (r_cnt != '0) begin
            r_acc <= w_step;
            r_b   <= {r_b[N-2:0], 1'b0};
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/ec_point_unit.sv
// rtl/ec_point_unit.sv - affine EC point add/double over GF(p) sharing one serial multiplier
module ec_point_unit
    import ec_pkg::*;
#(
    parameter int N = 231
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] p,
    input  logic [N-1:0] a,
    input  logic [N-1:0] x1,
    input  logic [N-1:0] y1,
    input  logic         inf1,
    input  logic [N-1:0] x2,
    input  logic [N-1:0] y2,
    input  logic         inf2,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] x3,
    output logic [N-1:0] y3,
    output logic         inf3
);
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    ec_state_t     r_state;
    logic [N-1:0]  r_p, r_a, r_x1, r_y1, r_x2, r_y2;
    logic          r_mode, r_inf1, r_inf2, r_dbl;
    logic [N-1:0]  r_t, r_num, r_den, r_inv, r_lam, r_rx, r_ry;
    logic          r_rinf, r_issued, r_sqmul;
    logic [BW-1:0] r_bit;
    logic          r_busy, r_done, r_inf3;
    logic [N-1:0]  r_x3, r_y3;

    logic [N-1:0]  w_ma, w_mb, w_mul_p, w_exp, w_x2eff;
    logic          w_mul_state, w_mul_start, w_mul_done;
    logic [N-1:0]  w_t2, w_t3, w_num_dbl, w_den_dbl, w_num_add, w_den_add;
    logic [N-1:0]  w_x3a, w_x3, w_x1_m_x3, w_fin;

    function automatic logic [N-1:0] fadd(input logic [N-1:0] u, input logic [N-1:0] v,
                                          input logic [N-1:0] m);
        return N'(mod_add(EC_W_MAX'(u), EC_W_MAX'(v), EC_W_MAX'(m)));
    endfunction

    function automatic logic [N-1:0] fsub(input logic [N-1:0] u, input logic [N-1:0] v,
                                          input logic [N-1:0] m);
        return N'(mod_sub(EC_W_MAX'(u), EC_W_MAX'(v), EC_W_MAX'(m)));
    endfunction

    assign w_exp     = r_p - N'(2);
    assign w_x2eff   = r_dbl ? r_x1 : r_x2;
    assign w_t2      = fadd(r_t, r_t, r_p);
    assign w_t3      = fadd(w_t2, r_t, r_p);
    assign w_num_dbl = fadd(w_t3, r_a, r_p);
    assign w_den_dbl = fadd(r_y1, r_y1, r_p);
    assign w_num_add = fsub(r_y2, r_y1, r_p);
    assign w_den_add = fsub(r_x2, r_x1, r_p);
    assign w_x3a     = fsub(r_t, r_x1, r_p);
    assign w_x3      = fsub(w_x3a, w_x2eff, r_p);
    assign w_x1_m_x3 = fsub(r_x1, r_rx, r_p);
    assign w_fin     = fsub(r_ry, r_y1, r_p);

    always_comb begin
        w_ma        = '0;
        w_mb        = '0;
        w_mul_state = 1'b1;
        case (r_state)
            S_SQR:   begin w_ma = r_x1;  w_mb = r_x1; end
            S_INV:   begin w_ma = r_inv; w_mb = r_sqmul ? r_den : r_inv; end
            S_LAM:   begin w_ma = r_num; w_mb = r_inv; end
            S_LAM2:  begin w_ma = r_lam; w_mb = r_lam; end
            S_Y3:    begin w_ma = r_lam; w_mb = w_x1_m_x3; end
            default: w_mul_state = 1'b0;
        endcase
    end

    assign w_mul_start = w_mul_state && !r_issued;

    mod_mul_serial #(.N(N)) u_mul (
        .clk     (clk),
        .rst_n   (reset),
        .i_start (w_mul_start),
        .i_a     (w_ma),
        .i_b     (w_mb),
        .i_p     (r_p),
        .o_done  (w_mul_done),
        .o_p     (w_mul_p)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            {r_p, r_a, r_x1, r_y1, r_x2, r_y2} <= '0;
            {r_mode, r_inf1, r_inf2, r_dbl} <= '0;
            {r_t, r_num, r_den, r_inv, r_lam, r_rx, r_ry} <= '0;
            {r_rinf, r_issued, r_sqmul} <= '0;
            r_bit  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_inf3 <= 1'b0;
            r_x3   <= '0;
            r_y3   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_mul_start)
                r_issued <= 1'b1;
            if (w_mul_done)
                r_issued <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    {r_p, r_a, r_x1, r_y1, r_x2, r_y2} <= {p, a, x1, y1, x2, y2};
                    {r_mode, r_inf1, r_inf2} <= {mode, inf1, inf2};
                    r_busy  <= 1'b1;
                    r_state <= S_SPECIAL;
                end
                S_SPECIAL: begin
                    r_rx   <= '0;
                    r_ry   <= '0;
                    r_rinf <= 1'b0;
                    r_dbl  <= 1'b1;
                    r_state <= S_DONE;
                    if (r_mode == MODE_DBL) begin
                        if (r_inf1 || r_y1 == '0) r_rinf <= 1'b1;
                        else r_state <= S_SQR;
                    end else if (r_inf1) begin
                        r_rx   <= r_inf2 ? '0 : r_x2;
                        r_ry   <= r_inf2 ? '0 : r_y2;
                        r_rinf <= r_inf2;
                    end else if (r_inf2) begin
                        r_rx <= r_x1;
                        r_ry <= r_y1;
                    end else if (r_x1 == r_x2) begin
                        // Equal x: either P + (-P) or P + P, which takes the doubling path.
                        if (r_y1 != r_y2 || r_y1 == '0) r_rinf <= 1'b1;
                        else r_state <= S_SQR;
                    end else begin
                        r_dbl   <= 1'b0;
                        r_state <= S_NUMDEN;
                    end
                end
                S_SQR: if (w_mul_done) begin
                    r_t     <= w_mul_p;
                    r_state <= S_NUMDEN;
                end
                S_NUMDEN: begin
                    r_num   <= r_dbl ? w_num_dbl : w_num_add;
                    r_den   <= r_dbl ? w_den_dbl : w_den_add;
                    r_inv   <= N'(1);
                    r_bit   <= BW'(N - 1);
                    r_sqmul <= 1'b0;
                    r_state <= S_INV;
                end
                S_INV: if (w_mul_done) begin
                    r_inv <= w_mul_p;
                    if (!r_sqmul && w_exp[r_bit]) begin
                        r_sqmul <= 1'b1;
                    end else begin
                        r_sqmul <= 1'b0;
                        if (r_bit == '0) r_state <= S_LAM;
                        else r_bit <= r_bit - BW'(1);
                    end
                end
                S_LAM: if (w_mul_done) begin
                    r_lam   <= w_mul_p;
                    r_state <= S_LAM2;
                end
                S_LAM2: if (w_mul_done) begin
                    r_t     <= w_mul_p;
                    r_state <= S_X3;
                end
                S_X3: begin
                    r_rx    <= w_x3;
                    r_state <= S_Y3;
                end
                S_Y3: if (w_mul_done) begin
                    r_ry    <= w_mul_p;
                    r_state <= S_FIN;
                end
                S_FIN: begin
                    r_ry    <= w_fin;
                    r_rinf  <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_x3    <= r_rx;
                    r_y3    <= r_ry;
                    r_inf3  <= r_rinf;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign x3   = r_x3;
    assign y3   = r_y3;
    assign inf3 = r_inf3;

endmodule

// File: tb/tb_ec_point_unit.sv
// tb/tb_ec_point_unit.sv - directed vectors on y^2 = x^3 + x + 1 over GF(23)
module tb_ec_point_unit;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [N-1:0] p = 8'd23;
    logic [N-1:0] a = 8'd1;
    logic [N-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic         inf1 = 1'b0, inf2 = 1'b0;
    logic         busy, done, inf3;
    logic [N-1:0] x3, y3;

    int n_vec = 0;
    int n_bad = 0;

    // Latencies for p=23, N=8, popcount(21)=3: add 5+14*9, double 5+15*9.
    localparam int L_ADD = 131;
    localparam int L_DBL = 140;
    localparam int L_DEG = 2;

    ec_point_unit #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .p(p), .a(a),
        .x1(x1), .y1(y1), .inf1(inf1), .x2(x2), .y2(y2), .inf2(inf2),
        .busy(busy), .done(done), .x3(x3), .y3(y3), .inf3(inf3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic m,
                          input int ax1, input int ay1, input logic ai1,
                          input int ax2, input int ay2, input logic ai2,
                          input logic inject,
                          input int ex3, input int ey3, input logic einf, input int elat);
        int c;
        @(negedge clk);
        mode = m; x1 = N'(ax1); y1 = N'(ay1); inf1 = ai1;
        x2 = N'(ax2); y2 = N'(ay2); inf2 = ai2;
        start = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; optionally hold start while busy.
        start = inject;
        mode = ~m; x1 = 8'd4; y1 = 8'd0; inf1 = ~ai1;
        x2 = 8'd5; y2 = 8'd1; inf2 = ~ai2;
        c = 0;
        while (c < 2000) begin
            @(posedge clk);
            #1;
            c++;
            start = 1'b0;
            if (done) break;
        end
        chk({tag, ".latency"}, c, elat);
        chk({tag, ".busy_at_done"}, int'(busy), 0);
        chk({tag, ".x3"}, int'(x3), ex3);
        chk({tag, ".y3"}, int'(y3), ey3);
        chk({tag, ".inf3"}, int'(inf3), int'(einf));
        @(posedge clk);
        #1;
        chk({tag, ".done_width"}, int'(done), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.x3", int'(x3), 0);
        chk("rst.y3", int'(y3), 0);
        chk("rst.inf3", int'(inf3), 0);
        @(negedge clk);
        reset = 1'b1;

        run_op("add",      1'b0, 3, 10, 1'b0, 9, 7,  1'b0, 1'b0, 17, 20, 1'b0, L_ADD);
        run_op("dbl",      1'b1, 3, 10, 1'b0, 0, 0,  1'b0, 1'b0, 7,  12, 1'b0, L_DBL);
        run_op("promote",  1'b0, 3, 10, 1'b0, 3, 10, 1'b0, 1'b0, 7,  12, 1'b0, L_DBL);
        run_op("inf1",     1'b0, 5, 1,  1'b1, 9, 7,  1'b0, 1'b0, 9,  7,  1'b0, L_DEG);
        run_op("inf2",     1'b0, 3, 10, 1'b0, 5, 1,  1'b1, 1'b0, 3,  10, 1'b0, L_DEG);
        run_op("dbl_inf",  1'b1, 3, 10, 1'b1, 9, 7,  1'b0, 1'b0, 0,  0,  1'b1, L_DEG);
        run_op("add_neg",  1'b0, 3, 10, 1'b0, 3, 13, 1'b0, 1'b0, 0,  0,  1'b1, L_DEG);
        run_op("dbl_y0",   1'b1, 4, 0,  1'b0, 9, 7,  1'b0, 1'b0, 0,  0,  1'b1, L_DEG);
        run_op("busy_ign", 1'b0, 3, 10, 1'b0, 9, 7,  1'b0, 1'b1, 17, 20, 1'b0, L_ADD);

        // Abort during the inversion; outputs currently hold (17,20).
        @(negedge clk);
        mode = 1'b1; x1 = 8'd3; y1 = 8'd10; inf1 = 1'b0; inf2 = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort.busy", int'(busy), 0);
        chk("abort.done", int'(done), 0);
        chk("abort.x3", int'(x3), 0);
        chk("abort.y3", int'(y3), 0);
        chk("abort.inf3", int'(inf3), 0);
        @(negedge clk);
        reset = 1'b1;

        run_op("post_rst", 1'b1, 3, 10, 1'b0, 0, 0, 1'b0, 1'b0, 7, 12, 1'b0, L_DBL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
